// File: rtl/store_data_packer_if.sv
// Store-path bus: MEM-stage store request in, packed store out to data memory.
// master = store issuer / memory side, slave = the packer.
interface store_data_packer_if #(
  parameter int AW    = 32,
  parameter int DEPTH = 2
);
  logic                     st_valid;
  logic                     st_ready;
  logic [AW-1:0]            st_addr;
  logic [31:0]              st_data;
  logic [1:0]               st_size;
  logic                     st_fault;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [AW-1:0]            mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_be;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ready,
    input  st_ready, st_fault, mem_valid, mem_addr, mem_wdata, mem_be, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ready,
    output st_ready, st_fault, mem_valid, mem_addr, mem_wdata, mem_be, count
  );
endinterface

// File: rtl/store_data_packer.sv
// MEM-stage store packer: lane-steers SB/SH/SW data, builds byte enables and
// queues packed stores in a small FIFO drained over a valid/ready handshake.

module store_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] off,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] bw,
  output logic       be,
  output logic [7:0] wbyte
);
  localparam logic [1:0] IDX = 2'(LANE);

  // byte data is replicated, half data alternates low/high byte per lane
  always_comb begin
    be    = 1'b0;
    wbyte = b0;
    case (size)
      2'b00: be = (off == IDX);
      2'b01: begin
        be    = (off[1] == IDX[1]);
        wbyte = IDX[0] ? b1 : b0;
      end
      2'b10: begin
        be    = 1'b1;
        wbyte = bw;
      end
      default: ;
    endcase
  end
endmodule

module store_data_packer #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  store_data_packer_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int PW        = $clog2(DEPTH);
  localparam int CW        = PW + 1;

  typedef struct packed {
    logic [AW-1:0]                addr;
    logic [NUM_LANES-1:0][7:0]    wdata;
    logic [NUM_LANES-1:0]         be;
  } st_entry_t;

  st_entry_t                   fifo_q [DEPTH];
  st_entry_t                   new_entry;
  st_entry_t                   head;
  logic [PW-1:0]               rd_ptr, wr_ptr;
  logic [CW-1:0]               cnt;
  logic                        fault_q;
  logic [NUM_LANES-1:0]        lane_be;
  logic [NUM_LANES-1:0][7:0]   lane_data;
  logic [1:0]                  off;
  logic                        illegal, accept, push, pop;

  assign off = bus.st_addr[1:0];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    store_lane #(.LANE(i)) u_lane (
      .size  (bus.st_size),
      .off   (off),
      .b0    (bus.st_data[7:0]),
      .b1    (bus.st_data[15:8]),
      .bw    (bus.st_data[8*i +: 8]),
      .be    (lane_be[i]),
      .wbyte (lane_data[i])
    );
  end

  always_comb begin
    illegal = 1'b0;
    case (bus.st_size)
      2'b01:   illegal = off[0];
      2'b10:   illegal = (off != 2'b00);
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  assign new_entry.addr  = {bus.st_addr[AW-1:2], 2'b00};
  assign new_entry.wdata = lane_data;
  assign new_entry.be    = lane_be;

  assign bus.st_ready = (cnt != CW'(DEPTH));
  assign accept       = bus.st_valid & bus.st_ready;
  assign push         = accept & ~illegal;
  assign pop          = (cnt != '0) & bus.mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= accept & illegal;
      if (push) begin
        fifo_q[wr_ptr] <= new_entry;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // When empty, the slot behind rd_ptr still holds the last popped entry
  // (or zeros after reset), so outputs keep their last value for free.
  assign head = (cnt != '0) ? fifo_q[rd_ptr] : fifo_q[rd_ptr - PW'(1)];

  assign bus.mem_valid = (cnt != '0);
  assign bus.mem_addr  = head.addr;
  assign bus.mem_wdata = head.wdata;
  assign bus.mem_be    = head.be;
  assign bus.st_fault  = fault_q;
  assign bus.count     = cnt;
endmodule
